// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory freeze.
// Combinational load/flush enables plus a small state FSM and event counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             pc_load,
    output logic             ifid_load,
    output logic             idex_load,
    output logic             exmem_load,
    output logic             memwb_load,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LOADUSE = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_lu;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // Load-use: EX load writes a register ID reads; x0 never hazards.
    assign w_lu = ex_memread && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (ex_rd == id_rs1)) ||
                   (id_use_rs2 && (ex_rd == id_rs2)));

    // Prioritised enables (mem_busy > branch > load-use) and next state.
    always_comb begin
        pc_load    = 1'b1;
        ifid_load  = 1'b1;
        idex_load  = 1'b1;
        exmem_load = 1'b1;
        memwb_load = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        w_next     = RUN;
        if (mem_busy) begin
            pc_load    = 1'b0;
            ifid_load  = 1'b0;
            idex_load  = 1'b0;
            exmem_load = 1'b0;
            memwb_load = 1'b0;
            w_next     = MEMWAIT;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_lu) begin
            pc_load    = 1'b0;
            ifid_load  = 1'b0;
            idex_flush = 1'b1;
            w_next     = LOADUSE;
        end
    end

    // State register; reset aborts any stall/wait sequence immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Saturating stall (PC held) and flush (IF/ID bubbled) counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_load && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (ifid_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: rule-level model checked every
// negedge plus directed scenarios with hand-computed literal expectations.
module tb_hazard_ctrl;

    localparam int CW   = 4;
    localparam int SMAX = 15;

    logic          clk;
    logic          rst;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2;
    logic          ex_memread, ex_branch_taken, mem_busy;
    logic          pc_load, ifid_load, idex_load, exmem_load, memwb_load;
    logic          ifid_flush, idex_flush;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    int m_state = 0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
        .pc_load(pc_load), .ifid_load(ifid_load), .idex_load(idex_load),
        .exmem_load(exmem_load), .memwb_load(memwb_load),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Hazard exists when a load in EX writes a nonzero reg used in ID.
    function automatic bit model_lu();
        if (!ex_memread || ex_rd == 0) return 0;
        if (id_use_rs1 && ex_rd == id_rs1) return 1;
        if (id_use_rs2 && ex_rd == id_rs2) return 1;
        return 0;
    endfunction

    // Expected {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush}.
    function automatic logic [6:0] model_out();
        if (mem_busy)        return 7'b00000_00;
        if (ex_branch_taken) return 7'b11111_11;
        if (model_lu())      return 7'b00111_01;
        return 7'b11111_00;
    endfunction

    function automatic logic [6:0] dut_out();
        return {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                ifid_flush, idex_flush};
    endfunction

    // Model of architectural state, advanced on the same edges as the DUT.
    always @(posedge clk or posedge rst) begin
        logic [6:0] e;
        if (rst) begin
            m_state = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            e = model_out();
            if (!e[6] && m_stall < SMAX) m_stall = m_stall + 1;
            if (e[1] && m_flush < SMAX) m_flush = m_flush + 1;
            if (mem_busy) m_state = 2;
            else if (!ex_branch_taken && model_lu()) m_state = 1;
            else m_state = 0;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("outs", int'(dut_out()), int'(model_out()));
        check("state", int'(state), m_state);
        check("stall_cnt", int'(stall_cnt), m_stall);
        check("flush_cnt", int'(flush_cnt), m_flush);
    end

    task automatic drive(input logic mb, input logic br, input logic mr,
                         input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic u1, input logic u2);
        mem_busy        = mb;
        ex_branch_taken = br;
        ex_memread      = mr;
        ex_rd           = rd;
        id_rs1          = r1;
        id_rs2          = r2;
        id_use_rs1      = u1;
        id_use_rs2      = u2;
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        #3;
        check("rst_state", int'(state), 0);
        check("rst_stall", int'(stall_cnt), 0);
        check("rst_flush", int'(flush_cnt), 0);
        // Outputs follow inputs while in reset
        drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("rst_freeze", int'(dut_out()), 7'b0000000);
        idle();
        tick();
        rst = 1'b0;
        tick();

        // Load-use on rs1
        drive(0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
        check("lu_pc", int'(pc_load), 0);
        check("lu_ifid", int'(ifid_load), 0);
        check("lu_idexfl", int'(idex_flush), 1);
        check("lu_exmem", int'(exmem_load), 1);
        tick();
        idle();
        check("lu_state", int'(state), 1);
        check("lu_stall", int'(stall_cnt), 1);
        tick();
        check("lu_back", int'(state), 0);

        // rs2 match only counts when rs2 is used
        drive(0, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0);
        check("rs2_unused", int'(pc_load), 1);
        tick();
        drive(0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 1);
        check("rs2_used", int'(pc_load), 0);
        tick();
        drive(0, 0, 0, 5'd7, 5'd7, 5'd7, 1, 1);
        check("no_load", int'(dut_out()), 7'b1111100);
        tick();

        // x0 never hazards
        do_reset();
        drive(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        check("x0_outs", int'(dut_out()), 7'b1111100);
        tick();
        check("x0_state", int'(state), 0);

        // Memory freeze with a branch held in EX
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            check("mw_outs", int'(dut_out()), 7'b0000000);
            tick();
        end
        check("mw_state", int'(state), 2);
        check("mw_stall", int'(stall_cnt), 3);
        drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("mw_brfl", int'(dut_out()), 7'b1111111);
        tick();
        idle();
        check("mw_flush", int'(flush_cnt), 1);
        check("mw_stall2", int'(stall_cnt), 3);
        check("mw_run", int'(state), 0);

        // Branch beats load-use
        do_reset();
        drive(0, 1, 1, 5'd9, 5'd9, 5'd0, 1, 0);
        check("br_lu", int'(dut_out()), 7'b1111111);
        tick();
        idle();
        check("br_lu_st", int'(state), 0);
        check("br_lu_stall", int'(stall_cnt), 0);
        check("br_lu_flush", int'(flush_cnt), 1);

        // Load-use held 20 cycles: repeated stalls, saturation
        do_reset();
        drive(0, 0, 1, 5'd3, 5'd0, 5'd3, 0, 1);
        repeat (20) tick();
        check("sat_stall", int'(stall_cnt), 15);
        check("sat_state", int'(state), 1);
        drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        repeat (20) tick();
        check("sat_flush", int'(flush_cnt), 15);

        // Async reset mid-MEMWAIT
        do_reset();
        drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        tick();
        tick();
        check("pre_ar_state", int'(state), 2);
        #2;
        rst = 1'b1;
        #1;
        check("ar_state", int'(state), 0);
        check("ar_stall", int'(stall_cnt), 0);
        check("ar_flush", int'(flush_cnt), 0);
        #2;
        rst = 1'b0;
        idle();
        tick();
        check("ar_after", int'(state), 0);
        check("ar_after_st", int'(stall_cnt), 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
